// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode values, FSM states and
// the latched request record.
package alu_pkg;

  // ALU opcode encodings; 3'b110 and 3'b111 are reserved and yield zero.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOTA = 3'b101;

  // Arbiter FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Operation captured from the granted requester.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       id;
  } arb_req_t;

  // Zero flag: high iff every result bit is clear.
  function automatic logic is_zero(input logic [7:0] value);
    return (value == 8'h00);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU: result, carry/borrow and zero flag.
module alu_arbiter_alu
  import alu_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [8:0] wide_s;

  // Evaluate the selected operation as a 9-bit value; bit 8 is carry/borrow.
  always_comb begin
    wide_s = 9'd0;
    case (op_i)
      ALU_ADD:  wide_s = {1'b0, a_i} + {1'b0, b_i};
      ALU_SUB:  wide_s = {1'b0, a_i} - {1'b0, b_i};
      ALU_AND:  wide_s = {1'b0, a_i & b_i};
      ALU_OR:   wide_s = {1'b0, a_i | b_i};
      ALU_XOR:  wide_s = {1'b0, a_i ^ b_i};
      ALU_NOTA: wide_s = {1'b0, ~a_i};
      default:  wide_s = 9'd0;
    endcase
  end

  assign result_o = wide_s[7:0];
  assign carry_o  = wide_s[8];
  assign zero_o   = is_zero(wide_s[7:0]);

endmodule : alu_arbiter_alu

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing a single ALU. One operation
// is in flight at a time: IDLE accepts, EXEC registers the ALU outputs,
// RESP holds the response until the consumer takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req1_a,
  input  logic [7:0] req0_b,
  input  logic [7:0] req1_b,
  input  logic [2:0] req0_op,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       busy
);

  // Last-grant starts at the highest index so req0 is favoured first.
  localparam logic LAST_GRANT_INIT = 1'(NUM_REQ - 1);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  arb_req_t   req_q, req_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;
  logic       carry_q, carry_d;

  logic       grant_id_s;
  logic       accept_s;
  logic       rsp_done_s;
  logic [7:0] alu_result_s;
  logic       alu_carry_s;
  logic       alu_zero_s;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // Handshake qualifiers; reset suppresses any accept in the same cycle.
  always_comb begin
    accept_s   = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !reset;
    rsp_done_s = (state_q == ST_RESP) && rsp_ready;
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: readys follow the grant only in IDLE, response flag in RESP.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req0_ready = accept_s && !grant_id_s;
        req1_ready = accept_s && grant_id_s;
        busy       = 1'b0;
      end
      ST_EXEC: begin
        busy = 1'b1;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath next-state: capture on accept, register ALU in EXEC, rotate grant on completion.
  always_comb begin
    req_d        = req_q;
    result_d     = result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    if (accept_s) begin
      if (grant_id_s) begin
        req_d = '{a: req1_a, b: req1_b, op: req1_op, id: 1'b1};
      end else begin
        req_d = '{a: req0_a, b: req0_b, op: req0_op, id: 1'b0};
      end
    end else begin
      req_d = req_q;
    end
    if (state_q == ST_EXEC) begin
      result_d = alu_result_s;
      zero_d   = alu_zero_s;
      carry_d  = alu_carry_s;
    end else begin
      result_d = result_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
    end
    if (rsp_done_s) begin
      last_grant_d = req_q.id;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Datapath registers; reset clears the response and drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= '0;
      result_q     <= 8'h00;
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      last_grant_q <= LAST_GRANT_INIT;
    end else begin
      req_q        <= req_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
    end
  end

  alu_arbiter_alu u_alu (
    .a_i      (req_q.a),
    .b_i      (req_q.b),
    .op_i     (req_q.op),
    .result_o (alu_result_s),
    .carry_o  (alu_carry_s),
    .zero_o   (alu_zero_s)
  );

  assign rsp_id     = req_q.id;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_carry  = carry_q;

endmodule : alu_arbiter
